multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select, including `o_imm_src` for the sign extender. Sits beside the datapath and reads opcode, funct fields and ALU flags from the instruction register. Stalls on a ready-based memory handshake.

---
 rtl/multicycle_ctrl_pkg.sv | 37 +++
 rtl/multicycle_ctrl_branch_cond.sv | 16 +
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// riscv_definitions: shared types and opcode constants for the multicycle RV32I control path.
// Optional S_TRAP state exists only when RISCV_CTRL_ILLEGAL_TRAP_EN is defined.
package riscv_definitions;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  typedef enum logic [2:0] {IMM_I, IMM_IS, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_t;
  typedef enum logic [1:0] {A_PC, A_OLDPC, A_RS1, A_ZERO} alu_src_a_t;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} alu_src_b_t;
  typedef enum logic [1:0] {RES_ALUOUT, RES_MEMDATA, RES_ALU} result_src_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} alu_op_t;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_LUI, S_AUIPC, S_ALUWB, S_BRANCH, S_JALR, S_JAL
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } ctrl_state_t;
  // shift-immediates (funct3 001/101) use the shamt form of the I immediate
  function automatic imm_src_t imm_decode(input logic [6:0] opc, input logic [2:0] f3);
    case (opc)
      OPC_OP_IMM:         return (f3[1:0] == 2'b01) ? IMM_IS : IMM_I;
      OPC_STORE:          return IMM_S;
      OPC_BRANCH:         return IMM_B;
      OPC_LUI, OPC_AUIPC: return IMM_U;
      OPC_JAL:            return IMM_J;
      default:            return IMM_I;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_ctrl_branch_cond.sv
// branch_cond: branch-taken decision from funct3 and ALU flags.
// in: i_funct3, i_zero, i_lt, i_ltu; out: o_taken, o_illegal (funct3 010/011).
module branch_cond (
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_lt,
  input  logic       i_ltu,
  output logic       o_taken,
  output logic       o_illegal
);
  logic flag;
  // funct3[0] inverts the base condition (beq/bne, blt/bge, bltu/bgeu)
  assign flag      = i_funct3[2] ? (i_funct3[1] ? i_ltu : i_lt) : i_zero;
  assign o_illegal = i_funct3[2:1] == 2'b01;
  assign o_taken   = !o_illegal && (flag ^ i_funct3[0]);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core.
// in: i_clk, i_rst (async, active-high), IR fields, ALU flags, i_mem_ready.
// out: memory strobes, write enables, mux selects, o_imm_src, o_bus_err, o_illegal.
// RISCV_CTRL_ILLEGAL_TRAP_EN: illegal encodings lock in S_TRAP instead of acting as NOPs.
module multicycle_ctrl
  import riscv_definitions::*;
#(
  parameter int MEM_TIMEOUT_CYCLES = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_lt,
  input  logic       i_ltu,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_adr_src,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic       o_reg_we,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_op,
  output imm_src_t   o_imm_src,
  output logic       o_bus_err,
  output logic       o_illegal
);
  // counter only needs to hold 0..MEM_TIMEOUT_CYCLES-1
  localparam int CW = MEM_TIMEOUT_CYCLES > 2 ? $clog2(MEM_TIMEOUT_CYCLES) : 1;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  localparam ctrl_state_t S_ILL = S_TRAP;
`else
  localparam ctrl_state_t S_ILL = S_FETCH;
`endif
  ctrl_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic taken, br_illegal, stall, timeout, unused_funct7b5;
  assign unused_funct7b5 = i_funct7b5;
  branch_cond u_branch_cond (
    .i_funct3 (i_funct3),
    .i_zero   (i_zero),
    .i_lt     (i_lt),
    .i_ltu    (i_ltu),
    .o_taken  (taken),
    .o_illegal(br_illegal)
  );
  assign stall   = MEM_TIMEOUT_CYCLES != 0 && o_mem_req && !i_mem_ready;
  assign timeout = stall && cnt_q == CW'(MEM_TIMEOUT_CYCLES - 1);
  assign o_bus_err = timeout;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  assign o_illegal = !i_rst && state_q == S_TRAP;
`else
  assign o_illegal = 1'b0;
`endif
  assign o_imm_src = i_rst ? IMM_I : imm_decode(i_opcode, i_funct3);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (i_opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_OP:              state_d = S_EXECR;
          OPC_OP_IMM:          state_d = S_EXECI;
          OPC_BRANCH:          state_d = br_illegal ? S_ILL : S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          OPC_JALR:            state_d = S_JALR;
          OPC_LUI:             state_d = S_LUI;
          OPC_AUIPC:           state_d = S_AUIPC;
          OPC_FENCE:           state_d = S_FETCH;
          default:             state_d = S_ILL;
        endcase
      S_MEMADR:   state_d = i_opcode == OPC_STORE ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = i_mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = i_mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL: state_d = S_ALUWB;
      S_JALR:     state_d = S_JAL;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FETCH;
    // a timeout in FETCH stays in FETCH, so it must clear the counter explicitly
    cnt_d = (timeout || state_d != state_q) ? '0 : stall ? cnt_q + 1'b1 : cnt_q;
  end
  always_comb begin
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_adr_src    = 1'b0;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_reg_we     = 1'b0;
    o_alu_src_a  = A_PC;
    o_alu_src_b  = B_RS2;
    o_result_src = RES_ALUOUT;
    o_alu_op     = ALU_ADD;
    if (!i_rst)
      case (state_q)
        S_FETCH: begin
          o_mem_req    = 1'b1;
          o_ir_we      = i_mem_ready;
          o_pc_we      = i_mem_ready;
          o_alu_src_b  = B_FOUR;
          o_result_src = RES_ALU;
        end
        S_DECODE: begin
          o_alu_src_a = A_OLDPC;
          o_alu_src_b = B_IMM;
        end
        S_MEMADR, S_JALR: begin
          o_alu_src_a = A_RS1;
          o_alu_src_b = B_IMM;
        end
        S_MEMREAD: begin
          o_mem_req = 1'b1;
          o_adr_src = 1'b1;
        end
        S_MEMWB: begin
          o_result_src = RES_MEMDATA;
          o_reg_we     = 1'b1;
        end
        S_MEMWRITE: begin
          o_mem_req = 1'b1;
          o_mem_we  = 1'b1;
          o_adr_src = 1'b1;
        end
        S_EXECR: begin
          o_alu_src_a = A_RS1;
          o_alu_op    = ALU_FUNCT;
        end
        S_EXECI: begin
          o_alu_src_a = A_RS1;
          o_alu_src_b = B_IMM;
          o_alu_op    = ALU_FUNCT;
        end
        S_LUI: begin
          o_alu_src_a = A_ZERO;
          o_alu_src_b = B_IMM;
        end
        S_AUIPC: begin
          o_alu_src_a = A_OLDPC;
          o_alu_src_b = B_IMM;
        end
        S_ALUWB: o_reg_we = 1'b1;
        S_BRANCH: begin
          o_alu_src_a = A_RS1;
          o_alu_op    = ALU_SUB;
          o_pc_we     = taken;
        end
        S_JAL: begin
          o_alu_src_a = A_OLDPC;
          o_alu_src_b = B_FOUR;
          o_pc_we     = 1'b1;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl with MEM_TIMEOUT_CYCLES=4.
module tb_multicycle_ctrl;
  import riscv_definitions::*;
  localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SMWB = 4, SMW = 5, SER = 6, SEI = 7;
  localparam int SLUI = 8, SAU = 9, SAWB = 10, SBR = 11, SJR = 12, SJ = 13, STRAP = 14;
  typedef struct {
    logic [18:0] v;
    string       n;
  } exp_t;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic [6:0] i_opcode = '0;
  logic [2:0] i_funct3 = '0;
  logic i_funct7b5 = 1'b0, i_zero = 1'b0, i_lt = 1'b0, i_ltu = 1'b0, i_mem_ready = 1'b0;
  logic o_mem_req, o_mem_we, o_adr_src, o_ir_we, o_pc_we, o_reg_we, o_bus_err, o_illegal;
  logic [1:0] o_alu_src_a, o_alu_src_b, o_result_src, o_alu_op;
  imm_src_t o_imm_src;
  logic [18:0] act;
  exp_t exp_q[$];
  exp_t e_m;
  int n_chk = 0, n_fail = 0;
  imm_src_t cur_imm = IMM_I;
  string tname = "reset";
  multicycle_ctrl #(.MEM_TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_funct7b5(i_funct7b5), .i_zero(i_zero), .i_lt(i_lt), .i_ltu(i_ltu),
    .i_mem_ready(i_mem_ready), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_adr_src(o_adr_src), .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_reg_we(o_reg_we),
    .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_result_src(o_result_src),
    .o_alu_op(o_alu_op), .o_imm_src(o_imm_src), .o_bus_err(o_bus_err), .o_illegal(o_illegal)
  );
  always #5 i_clk = ~i_clk;
  assign act = {o_mem_req, o_mem_we, o_adr_src, o_ir_we, o_pc_we, o_reg_we, o_alu_src_a,
                o_alu_src_b, o_result_src, o_alu_op, o_imm_src, o_bus_err, o_illegal};
  always @(negedge i_clk)
    if (exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      n_chk++;
      if (act !== e_m.v) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e_m.n, act, e_m.v);
      end
    end
  task automatic chk(input logic ok, input string nm);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %b", nm, act);
    end
  endtask
  function automatic logic [18:0] ev(input int s, input logic rdy, input logic tk, input logic berr);
    logic [5:0] st;
    logic [7:0] sel;
    logic il;
    st = '0;
    sel = '0;
    il = 1'b0;
    case (s)
      SF:    begin st = {3'b100, rdy, rdy, 1'b0}; sel = 8'b00_10_10_00; end
      SD:    sel = 8'b01_01_00_00;
      SMA:   sel = 8'b10_01_00_00;
      SMR:   st = 6'b101000;
      SMWB:  begin st = 6'b000001; sel = 8'b00_00_01_00; end
      SMW:   st = 6'b111000;
      SER:   sel = 8'b10_00_00_10;
      SEI:   sel = 8'b10_01_00_10;
      SLUI:  sel = 8'b11_01_00_00;
      SAU:   sel = 8'b01_01_00_00;
      SAWB:  st = 6'b000001;
      SBR:   begin st = {4'b0000, tk, 1'b0}; sel = 8'b10_00_00_01; end
      SJR:   sel = 8'b10_01_00_00;
      SJ:    begin st = 6'b000010; sel = 8'b01_10_00_00; end
      STRAP: il = 1'b1;
      default: ;
    endcase
    return {st, sel, cur_imm, berr, il};
  endfunction
  task automatic step(input int s, input logic rdy, input logic tk = 1'b0, input logic berr = 1'b0);
    i_mem_ready = rdy;
    exp_q.push_back('{v: ev(s, rdy, tk, berr), n: $sformatf("%s/s%0d", tname, s)});
    @(posedge i_clk);
    #1;
  endtask
  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    chk(act === 19'b0, "reset_async");
    exp_q.push_back('{v: 19'b0, n: "reset_a"});
    @(posedge i_clk);
    #1;
    exp_q.push_back('{v: 19'b0, n: "reset_b"});
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask
  task automatic set_instr(input string nm, input logic [6:0] opc, input logic [2:0] f3, input imm_src_t imm);
    tname = nm;
    i_opcode = opc;
    i_funct3 = f3;
    cur_imm = imm;
  endtask
  initial begin
    @(posedge i_clk);
    #1;
    do_reset();
    set_instr("lw_rst", OPC_LOAD, 3'b010, IMM_I);
    step(SF, 1); step(SD, 1); step(SMA, 1); step(SMR, 0);
    do_reset();
    set_instr("add", OPC_OP, 3'b000, IMM_I);
    step(SF, 1); step(SD, 1); step(SER, 1); step(SAWB, 1);
    set_instr("lw_wait", OPC_LOAD, 3'b010, IMM_I);
    step(SF, 1); step(SD, 1); step(SMA, 1);
    step(SMR, 0); step(SMR, 0); step(SMR, 0); step(SMR, 1); step(SMWB, 1);
    set_instr("bne_t", OPC_BRANCH, 3'b001, IMM_B);
    i_zero = 1'b0;
    step(SF, 1); step(SD, 1); step(SBR, 1, 1);
    set_instr("bne_nt", OPC_BRANCH, 3'b001, IMM_B);
    i_zero = 1'b1;
    step(SF, 1); step(SD, 1); step(SBR, 1, 0);
    set_instr("beq_t", OPC_BRANCH, 3'b000, IMM_B);
    step(SF, 1); step(SD, 1); step(SBR, 1, 1);
    set_instr("bltu_t", OPC_BRANCH, 3'b110, IMM_B);
    i_zero = 1'b0;
    i_ltu = 1'b1;
    step(SF, 1); step(SD, 1); step(SBR, 1, 1);
    set_instr("bge_nt", OPC_BRANCH, 3'b101, IMM_B);
    i_lt = 1'b1;
    step(SF, 1); step(SD, 1); step(SBR, 1, 0);
    set_instr("slli", OPC_OP_IMM, 3'b001, IMM_IS);
    step(SF, 1); step(SD, 1); step(SEI, 1); step(SAWB, 1);
    set_instr("srai", OPC_OP_IMM, 3'b101, IMM_IS);
    i_funct7b5 = 1'b1;
    step(SF, 1); step(SD, 1); step(SEI, 1); step(SAWB, 1);
    i_funct7b5 = 1'b0;
    set_instr("addi", OPC_OP_IMM, 3'b000, IMM_I);
    step(SF, 1); step(SD, 1); step(SEI, 1); step(SAWB, 1);
    set_instr("jal", OPC_JAL, 3'b000, IMM_J);
    step(SF, 1); step(SD, 1); step(SJ, 1); step(SAWB, 1);
    set_instr("jalr", OPC_JALR, 3'b000, IMM_I);
    step(SF, 1); step(SD, 1); step(SJR, 1); step(SJ, 1); step(SAWB, 1);
    set_instr("lui", OPC_LUI, 3'b000, IMM_U);
    step(SF, 1); step(SD, 1); step(SLUI, 1); step(SAWB, 1);
    set_instr("auipc", OPC_AUIPC, 3'b000, IMM_U);
    step(SF, 1); step(SD, 1); step(SAU, 1); step(SAWB, 1);
    set_instr("sw", OPC_STORE, 3'b010, IMM_S);
    step(SF, 1); step(SD, 1); step(SMA, 1); step(SMW, 1);
    set_instr("sw_timeout", OPC_STORE, 3'b010, IMM_S);
    step(SF, 1); step(SD, 1); step(SMA, 1);
    step(SMW, 0); step(SMW, 0); step(SMW, 0);
    i_mem_ready = 1'b0;
    #1;
    chk(o_bus_err === 1'b1, "bus_err_expired");
    step(SMW, 0, 0, 1);
    set_instr("fetch_timeout_fence", OPC_FENCE, 3'b000, IMM_I);
    step(SF, 0); step(SF, 0); step(SF, 0); step(SF, 0, 0, 1);
    step(SF, 1); step(SD, 1);
    set_instr("bad_branch", OPC_BRANCH, 3'b010, IMM_B);
    step(SF, 1); step(SD, 1);
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    step(STRAP, 1); step(STRAP, 1);
    do_reset();
`endif
    set_instr("bad_opcode", 7'b1111111, 3'b000, IMM_I);
    step(SF, 1); step(SD, 1);
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    step(STRAP, 1); step(STRAP, 0); step(STRAP, 1);
    do_reset();
`endif
    set_instr("post", OPC_OP, 3'b000, IMM_I);
    step(SF, 1); step(SD, 1); step(SER, 1); step(SAWB, 1);
    @(negedge i_clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
